// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-M up/down counter with runtime modulus, synchronous load,
// combinational terminal-count look-ahead (tc) and a registered wrap pulse.
// Optional wrap-event counter on port wrap_cnt, enabled by defining MODN_WRAPCNT_EN.
module mod_n_updown_counter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned N      = 10,
    parameter int unsigned WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  mod_val,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              wrap
`ifdef MODN_WRAPCNT_EN
    ,
    output logic [WCNT_W-1:0] wrap_cnt
`endif
);

    // One extra bit so that a modulus of 2^WIDTH is representable.
    localparam int unsigned MW = WIDTH + 1;
    localparam logic [MW-1:0] NDef = MW'(N);

    logic [MW-1:0]    m;
    logic [MW-1:0]    m_minus1_full;
    logic [WIDTH-1:0] m_max;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;

    // Effective modulus: 0 selects the default, 1 is promoted to 2.
    always_comb begin
        m = {1'b0, mod_val};
        if (mod_val == '0) begin
            m = NDef;
        end else if (mod_val == WIDTH'(1)) begin
            m = MW'(2);
        end
        m_minus1_full = m - MW'(1);
        m_max         = m_minus1_full[WIDTH-1:0];
    end

    // Look-ahead terminal count, forced low while reset is asserted.
    always_comb begin
        tc = rstn & en & ~load & (up_dn ? (out_q == m_max) : (out_q == '0));
    end

    // Next-state: load beats count enable beats hold.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = ({1'b0, load_val} < m) ? load_val : m_max;
        end else if (en) begin
            if (up_dn) begin
                // >= also catches a count stranded above a shrunken modulus.
                if (out_q >= m_max) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (out_q == '0) begin
                    out_d  = m_max;
                    wrap_d = 1'b1;
                end else if (out_q > m_max) begin
                    out_d = m_max;
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap-pulse state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

`ifdef MODN_WRAPCNT_EN
    logic [WCNT_W-1:0] wcnt_q;

    // Saturating count of wrap pulses; only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q <= '0;
        end else if (wrap_q && (wcnt_q != '1)) begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
        end
    end

    assign wrap_cnt = wcnt_q;
`else
    logic [WCNT_W-1:0] unused_wcnt_w;
    assign unused_wcnt_w = '0;
`endif

endmodule
